// File: rtl/router_pkg.sv
// Shared constants and helpers for the parametrised router synchroniser.
package router_pkg;

    localparam int NUM_CH_DEF  = 3;
    localparam int TIMEOUT_DEF = 30;

    // Effective stall limit: a zero runtime setting falls back to the default.
    function automatic int eff_limit(input int cfg, input int dflt);
        return (cfg == 0) ? dflt : cfg;
    endfunction

    // Ceiling log2 for sizing channel-index fields.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/router_timeout_ch.sv
// One channel's stall-timeout counter, soft_reset pulse and sticky status.
module router_timeout_ch #(
    parameter int CNT_W = 5
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             empty,
    input  logic             read_enb,
    input  logic [CNT_W-1:0] limit,
    input  logic             clr_status,
    output logic             soft_reset,
    output logic             timeout_sticky
);

    logic [CNT_W-1:0] cnt;
    logic             fire;

    // Stalled valid data that has waited limit edges; >= so a lowered limit fires at once.
    assign fire = ~empty & ~read_enb & (cnt >= (limit - CNT_W'(1)));

    // Counter, registered flush pulse and sticky flag (set beats clear).
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            cnt            <= '0;
            soft_reset     <= 1'b0;
            timeout_sticky <= 1'b0;
        end else begin
            soft_reset <= fire;
            if (fire)
                timeout_sticky <= 1'b1;
            else if (clr_status)
                timeout_sticky <= 1'b0;
            if (empty || read_enb || fire)
                cnt <= '0;
            else
                cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/router_sync_n.sv
// Router synchroniser: header address latch, write steering, status and per-channel timeouts.
module router_sync_n
    import router_pkg::*;
#(
    parameter int NUM_CH  = NUM_CH_DEF,
    parameter int ADDR_W  = 2,
    parameter int CNT_W   = 5,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              detect_add,
    input  logic [ADDR_W-1:0] data_in,
    input  logic              write_enb_reg,
    input  logic [NUM_CH-1:0] read_enb,
    input  logic [NUM_CH-1:0] empty,
    input  logic [NUM_CH-1:0] full,
    input  logic [CNT_W-1:0]  timeout_cfg,
    input  logic              clr_status,
    output logic [NUM_CH-1:0] write_enb,
    output logic              fifo_full,
    output logic [NUM_CH-1:0] vld_out,
    output logic [NUM_CH-1:0] soft_reset,
    output logic              addr_err,
    output logic [NUM_CH-1:0] timeout_sticky
);

    logic [ADDR_W-1:0] addr_q;
    logic              addr_valid;
    logic              in_range;
    logic [CNT_W-1:0]  limit;

    // Compare at 32 bits so NUM_CH == 2**ADDR_W does not overflow.
    assign in_range = (32'(data_in) < 32'(NUM_CH));
    assign limit    = CNT_W'(eff_limit(int'(timeout_cfg), TIMEOUT));
    assign vld_out  = ~empty;

    // Header latch; addr_err is a single-cycle pulse per out-of-range header.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            addr_q     <= '0;
            addr_valid <= 1'b0;
            addr_err   <= 1'b0;
        end else begin
            addr_err <= detect_add & ~in_range;
            if (detect_add) begin
                addr_q     <= data_in;
                addr_valid <= in_range;
            end
        end
    end

    // Decode the latched address into write enable and the addressed full flag.
    always_comb begin
        write_enb = '0;
        fifo_full = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (addr_valid && (addr_q == ADDR_W'(i))) begin
                write_enb[i] = write_enb_reg;
                fifo_full    = full[i];
            end
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        router_timeout_ch #(.CNT_W(CNT_W)) u_ch (
            .clock          (clock),
            .resetn         (resetn),
            .empty          (empty[g]),
            .read_enb       (read_enb[g]),
            .limit          (limit),
            .clr_status     (clr_status),
            .soft_reset     (soft_reset[g]),
            .timeout_sticky (timeout_sticky[g])
        );
    end

endmodule

// File: tb/tb_router_sync_n.sv
// Directed bench for router_sync_n: address/steering table plus timeout sequences.
module tb_router_sync_n;

    logic       clock = 1'b0;
    logic       resetn;
    logic       detect_add;
    logic [1:0] data_in;
    logic       write_enb_reg;
    logic [2:0] read_enb, empty, full;
    logic [4:0] timeout_cfg;
    logic       clr_status;
    logic [2:0] write_enb, vld_out, soft_reset, timeout_sticky;
    logic       fifo_full, addr_err;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic       da;
        logic [1:0] din;
        logic       wer;
        logic [2:0] full;
        logic [2:0] empty;
        logic [2:0] exp_we;
        logic       exp_ff;
        logic       exp_err;
        logic [2:0] exp_vld;
    } vec_t;

    vec_t tbl[12];

    router_sync_n dut (
        .clock(clock), .resetn(resetn), .detect_add(detect_add), .data_in(data_in),
        .write_enb_reg(write_enb_reg), .read_enb(read_enb), .empty(empty), .full(full),
        .timeout_cfg(timeout_cfg), .clr_status(clr_status), .write_enb(write_enb),
        .fifo_full(fifo_full), .vld_out(vld_out), .soft_reset(soft_reset),
        .addr_err(addr_err), .timeout_sticky(timeout_sticky)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One rising edge, then sample 1 time unit later.
    task automatic edge_sample();
        @(posedge clock);
        #1;
    endtask

    task automatic stall_edges(input int n);
        for (int k = 0; k < n; k++) edge_sample();
    endtask

    initial begin
        //            da  din  wer  full    empty   we      ff    err   vld
        tbl[0]  = '{1'b1, 2'd1, 1'b1, 3'b000, 3'b111, 3'b010, 1'b0, 1'b0, 3'b000};
        tbl[1]  = '{1'b0, 2'd0, 1'b1, 3'b001, 3'b110, 3'b010, 1'b0, 1'b0, 3'b001};
        tbl[2]  = '{1'b0, 2'd0, 1'b1, 3'b010, 3'b101, 3'b010, 1'b1, 1'b0, 3'b010};
        tbl[3]  = '{1'b0, 2'd0, 1'b0, 3'b110, 3'b011, 3'b000, 1'b1, 1'b0, 3'b100};
        tbl[4]  = '{1'b1, 2'd3, 1'b1, 3'b111, 3'b111, 3'b000, 1'b0, 1'b1, 3'b000};
        tbl[5]  = '{1'b0, 2'd0, 1'b1, 3'b111, 3'b111, 3'b000, 1'b0, 1'b0, 3'b000};
        tbl[6]  = '{1'b1, 2'd2, 1'b1, 3'b011, 3'b111, 3'b100, 1'b0, 1'b0, 3'b000};
        tbl[7]  = '{1'b0, 2'd0, 1'b1, 3'b100, 3'b111, 3'b100, 1'b1, 1'b0, 3'b000};
        tbl[8]  = '{1'b1, 2'd0, 1'b1, 3'b001, 3'b111, 3'b001, 1'b1, 1'b0, 3'b000};
        tbl[9]  = '{1'b1, 2'd3, 1'b0, 3'b000, 3'b111, 3'b000, 1'b0, 1'b1, 3'b000};
        tbl[10] = '{1'b1, 2'd3, 1'b1, 3'b111, 3'b111, 3'b000, 1'b0, 1'b1, 3'b000};
        tbl[11] = '{1'b1, 2'd0, 1'b1, 3'b000, 3'b111, 3'b001, 1'b0, 1'b0, 3'b000};

        resetn = 1'b0; detect_add = 1'b0; data_in = '0; write_enb_reg = 1'b1;
        read_enb = '0; empty = 3'b111; full = 3'b111; timeout_cfg = '0; clr_status = 1'b0;
        #12;
        check("rst_write_enb", 32'(write_enb), 32'h0);
        check("rst_fifo_full", 32'(fifo_full), 32'h0);
        check("rst_addr_err", 32'(addr_err), 32'h0);
        check("rst_soft_reset", 32'(soft_reset), 32'h0);
        check("rst_sticky", 32'(timeout_sticky), 32'h0);
        @(negedge clock);
        resetn = 1'b1;
        edge_sample();
        check("post_rst_write_enb", 32'(write_enb), 32'h0);

        // Address latch, steering, fifo_full selection and addr_err pulses.
        for (int i = 0; i < 12; i++) begin
            @(negedge clock);
            detect_add = tbl[i].da; data_in = tbl[i].din; write_enb_reg = tbl[i].wer;
            full = tbl[i].full; empty = tbl[i].empty;
            edge_sample();
            check($sformatf("v%0d_write_enb", i), 32'(write_enb), 32'(tbl[i].exp_we));
            check($sformatf("v%0d_fifo_full", i), 32'(fifo_full), 32'(tbl[i].exp_ff));
            check($sformatf("v%0d_addr_err", i), 32'(addr_err), 32'(tbl[i].exp_err));
            check($sformatf("v%0d_vld_out", i), 32'(vld_out), 32'(tbl[i].exp_vld));
        end
        @(negedge clock);
        detect_add = 1'b0; empty = 3'b111; full = '0;
        edge_sample();

        // Default limit 30: pulses on edges 30 and 60 of a continuous stall.
        @(negedge clock);
        timeout_cfg = '0; empty[0] = 1'b0; read_enb[0] = 1'b0;
        for (int k = 1; k <= 60; k++) begin
            edge_sample();
            check($sformatf("t3_sr0_edge%0d", k), 32'(soft_reset[0]), 32'((k == 30) || (k == 60)));
        end
        @(negedge clock);
        empty[0] = 1'b1;
        edge_sample();
        check("t3_sticky_held", 32'(timeout_sticky), 32'h1);
        @(negedge clock);
        clr_status = 1'b1;
        edge_sample();
        check("t3_sticky_cleared", 32'(timeout_sticky), 32'h0);
        @(negedge clock);
        clr_status = 1'b0;

        // Limit 4: a read on the 4th edge suppresses the timeout.
        timeout_cfg = 5'd4; empty[2] = 1'b0; read_enb[2] = 1'b0;
        stall_edges(3);
        check("t4_no_sr_pre", 32'(soft_reset[2]), 32'h0);
        @(negedge clock);
        read_enb[2] = 1'b1;
        edge_sample();
        check("t4_read_suppress", 32'(soft_reset[2]), 32'h0);
        @(negedge clock);
        read_enb[2] = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            edge_sample();
            check($sformatf("t4_sr2_edge%0d", k), 32'(soft_reset[2]), 32'(k == 4));
        end
        @(negedge clock);
        empty[2] = 1'b1; clr_status = 1'b1;
        edge_sample();
        @(negedge clock);
        clr_status = 1'b0;

        // Lowering the limit below the running count fires on the next stall edge.
        timeout_cfg = '0; empty[1] = 1'b0; read_enb[1] = 1'b0;
        stall_edges(20);
        check("t5_no_sr_at20", 32'(soft_reset[1]), 32'h0);
        @(negedge clock);
        timeout_cfg = 5'd10;
        edge_sample();
        check("t5_sr_on_lower", 32'(soft_reset[1]), 32'h1);
        stall_edges(5);
        @(negedge clock);
        empty[1] = 1'b1;
        edge_sample();
        check("t5_empty_no_sr", 32'(soft_reset[1]), 32'h0);
        @(negedge clock);
        empty[1] = 1'b0;
        stall_edges(9);
        check("t5_restart_no_sr", 32'(soft_reset[1]), 32'h0);
        edge_sample();
        check("t5_restart_sr", 32'(soft_reset[1]), 32'h1);
        @(negedge clock);
        empty[1] = 1'b1; clr_status = 1'b1;
        edge_sample();

        // Set wins over clear in the same cycle.
        @(negedge clock);
        timeout_cfg = 5'd1; empty[2] = 1'b0; clr_status = 1'b1;
        edge_sample();
        check("set_wins_sr", 32'(soft_reset), 32'b100);
        check("set_wins_sticky", 32'(timeout_sticky), 32'b100);
        @(negedge clock);
        empty[2] = 1'b1;
        edge_sample();
        check("clr_after_set", 32'(timeout_sticky), 32'h0);
        @(negedge clock);
        clr_status = 1'b0;

        // Asynchronous reset cuts an in-flight pulse and drops the address.
        timeout_cfg = 5'd2; empty[0] = 1'b0; write_enb_reg = 1'b1;
        stall_edges(2);
        check("t6_sr_before", 32'(soft_reset[0]), 32'h1);
        check("t6_we_before", 32'(write_enb), 32'b001);
        #2;
        resetn = 1'b0;
        #1;
        check("t6_async_sr", 32'(soft_reset), 32'h0);
        check("t6_async_we", 32'(write_enb), 32'h0);
        check("t6_async_sticky", 32'(timeout_sticky), 32'h0);
        @(negedge clock);
        resetn = 1'b1; empty = 3'b111;
        stall_edges(2);
        check("t6_we_after_release", 32'(write_enb), 32'h0);
        @(negedge clock);
        detect_add = 1'b1; data_in = 2'd1;
        edge_sample();
        check("t6_we_new_addr", 32'(write_enb), 32'b010);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/router_sync_n.md
Name: router_sync_n

Overview:
- Parametrised successor to the 3-port router synchroniser.
- Latches the destination address from the header byte and steers the write enable to one of NUM_CH output FIFOs.
- Reports FIFO status for the addressed channel only, and flags header addresses that are out of range.
- Runs one stall-timeout counter per channel and issues a registered soft_reset pulse when a valid output is not read within a runtime-programmable limit.

Parameters:
- NUM_CH, 3, number of output channels/FIFOs (2..16).
- ADDR_W, 2, width of the header address field; 2**ADDR_W >= NUM_CH.
- CNT_W, 5, timeout counter width.
- TIMEOUT, 30, default timeout limit in cycles; 1 <= TIMEOUT <= 2**CNT_W-1.

Ports:
- clock  in  1  single clock, rising edge.
- resetn  in  1  asynchronous active-low reset.
- detect_add  in  1  header cycle: load data_in as the destination address.
- data_in  in  ADDR_W  address field of the header byte.
- write_enb_reg  in  1  write request from the FSM.
- read_enb  in  NUM_CH  per-channel read enable from the downstream readers.
- empty  in  NUM_CH  per-FIFO empty flag.
- full  in  NUM_CH  per-FIFO full flag.
- timeout_cfg  in  CNT_W  runtime timeout limit; 0 selects TIMEOUT.
- clr_status  in  1  clears timeout_sticky.
- write_enb  out  NUM_CH  one-hot write enable.
- fifo_full  out  1  full flag of the addressed FIFO.
- vld_out  out  NUM_CH  per-channel data valid.
- soft_reset  out  NUM_CH  one-cycle FIFO flush pulse.
- addr_err  out  1  one-cycle pulse: header address >= NUM_CH.
- timeout_sticky  out  NUM_CH  latched record that the channel has timed out.

Behaviour:
- Reset (async assert, sync release): addr_q=0, addr_valid=0, all counters 0, soft_reset=0, addr_err=0, timeout_sticky=0.
  - Consequence: write_enb=0 and fifo_full=0 until the first detect_add.
- Address latch: on a clock edge with detect_add=1: addr_q<=data_in, addr_valid<=(data_in<NUM_CH), addr_err<=(data_in>=NUM_CH).
  - addr_err is otherwise 0, so it is exactly a 1-cycle pulse.
- An invalid address keeps write_enb and fifo_full at 0 until the next valid detect_add.
- write_enb[i] = write_enb_reg & addr_valid & (addr_q==i). Combinational from registered state.
  - A detect_add in cycle n affects write_enb from cycle n+1.
- fifo_full = addr_valid & full[addr_q]. Combinational; other channels' full flags are ignored.
- vld_out[i] = ~empty[i]. Combinational.
- Effective limit L = (timeout_cfg==0) ? TIMEOUT : timeout_cfg. timeout_cfg is sampled every cycle.
- Per-channel counter, priority order:
  1. empty[i]=1: cnt<=0.
  2. vld_out[i] & read_enb[i]: cnt<=0.
  3. vld_out[i] & ~read_enb[i] & cnt>=L-1: cnt<=0, soft_reset[i]<=1, timeout_sticky[i]<=1.
  4. Otherwise: cnt<=cnt+1.
- Timeout timing: soft_reset[i] is high for exactly one cycle.
  - It asserts on the L-th consecutive edge with vld&~read.
  - Counting resumes from 0, so a persistent stall gives one pulse every L cycles.
- Limit changes mid-count: the >= compare means lowering the limit below the current count fires on the next stalled edge. The counter never wraps past 2**CNT_W-1.
- Simultaneous events:
  - A read in the timeout cycle suppresses the timeout.
  - The empty flag falling and a timeout cannot coincide, because empty clears the counter.
  - detect_add and a timeout are independent.
- Sticky status: timeout_sticky is set by any timeout and cleared by clr_status. Set wins if both occur in the same cycle.
- Reset mid-operation: all registers clear immediately and asynchronously. An in-flight soft_reset pulse is cut short.
- Channels are fully independent; multiple soft_reset bits may be high in the same cycle.

Decomposition:
- Shared package router_pkg:
  - default constants: NUM_CH_DEF=3, TIMEOUT_DEF=30.
  - function for the effective timeout limit.
  - clog2 helper.
- One natural sub-module: router_timeout_ch.
  - Contains one channel's counter, its soft_reset register and its sticky bit.
  - Instantiated NUM_CH times in a generate loop.
  - Ports: clock, resetn, empty, read_enb, limit, clr_status, soft_reset, timeout_sticky.
- The top level holds the address register, write_enb/fifo_full decode and addr_err.

Test Plan:
1. Reset, then detect_add with data_in=1, then write_enb_reg=1 -> write_enb=3'b010 from the next cycle; fifo_full follows full[1] only (full[0]=1 alone -> fifo_full=0).
2. detect_add with data_in=3, NUM_CH=3 -> addr_err high for exactly 1 cycle; write_enb=0 and fifo_full=0 while write_enb_reg=1; a following detect_add with data_in=2 restores write_enb=3'b100.
3. empty[0]=0, read_enb[0]=0, timeout_cfg=0 -> soft_reset[0] pulses 1 cycle on the 30th edge, again on the 60th; timeout_sticky[0]=1 until clr_status.
4. timeout_cfg=4, stall channel 2, read_enb[2]=1 on the 4th edge -> no soft_reset; then stall 4 more edges -> soft_reset[2] pulse.
5. Stall channel 1 to count 20, change timeout_cfg to 10 -> soft_reset[1] on the next edge. Set empty[1]=1 mid-count -> counter clears, no pulse.
6. Assert resetn=0 asynchronously, between edges, while soft_reset[0]=1 and addr_valid=1 -> all outputs 0 immediately; write_enb=0 after release until a new detect_add.
